// File: rtl/mux_scan_pkg.sv
// Shared encodings and widths for the mux scan sequencer.
package mux_scan_pkg;
    localparam int NUM_CH = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;
endpackage

// File: rtl/mux_8x1.sv
// Combinational 8:1 single-bit multiplexer; a is channel 0, h is channel 7.
module mux_8x1 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    input  logic sel0,
    input  logic sel1,
    input  logic sel2,
    output logic out
);
    logic [7:0] in_vec;

    assign in_vec = {h, g, f, e, d, c, b, a};
    assign out    = in_vec[{sel2, sel1, sel0}];
endmodule

// File: rtl/mux_scan_timer.sv
// Settle down-counter: expire flags the last settle cycle, or a zero-length settle at load time.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = value;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // While loading, report whether the settle phase is skipped entirely.
    assign expire = load ? (value == '0) : (cnt_reg == CNT_W'(1));
endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux through all channels, waits a settle time on each and
// assembles the samples into one parallel word with a start/busy/done handshake.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mux_out,
    output logic              sel0,
    output logic              sel1,
    output logic              sel2,
    output logic [NUM_CH-1:0] data,
    output logic              busy,
    output logic              done
);
    scan_state_e       state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [NUM_CH-1:0] shreg_reg, shreg_next;
    logic [NUM_CH-1:0] data_reg, data_next;
    logic              timer_load;
    logic              timer_expire;
    logic              last_ch;

    assign last_ch = (idx_reg == IDX_W'(NUM_CH - 1));

    // Kept separate from the FSM block so expire never feeds back into load.
    assign timer_load = ((state_reg == ST_IDLE || state_reg == ST_DONE) && start)
                     || (state_reg == ST_SAMPLE && !last_ch);

    mux_scan_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (CNT_W'(SETTLE_CYCLES)),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shreg_next = shreg_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                idx_next = '0;
                if (start) begin
                    state_next = timer_expire ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                shreg_next[idx_reg] = mux_out;
                if (!last_ch) begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = timer_expire ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    // Only a complete scan is ever published to data.
                    data_next  = {mux_out, shreg_reg[NUM_CH-2:0]};
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            shreg_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            shreg_reg <= shreg_next;
            data_reg  <= data_next;
        end
    end

    assign {sel2, sel1, sel0} = idx_reg;
    assign data = data_reg;
    assign busy = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
    assign done = (state_reg == ST_DONE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl + mux_8x1: instance 0 uses SETTLE_CYCLES=1, instance 1 uses 0.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    localparam int N_INST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [N_INST];
    logic       start_s [N_INST];
    logic [7:0] ch_s    [N_INST];
    logic [2:0] sel_o   [N_INST];
    logic [7:0] data_o  [N_INST];
    logic       busy_o  [N_INST];
    logic       done_o  [N_INST];
    bit         chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int S = (gi == 0) ? 1 : 0;
        logic       sel0, sel1, sel2, mux_out, busy, done;
        logic [7:0] data;

        mux_8x1 u_mux (
            .a(ch_s[gi][0]), .b(ch_s[gi][1]), .c(ch_s[gi][2]), .d(ch_s[gi][3]),
            .e(ch_s[gi][4]), .f(ch_s[gi][5]), .g(ch_s[gi][6]), .h(ch_s[gi][7]),
            .sel0(sel0), .sel1(sel1), .sel2(sel2), .out(mux_out)
        );

        mux_scan_ctrl #(.SETTLE_CYCLES(S)) u_dut (
            .clk(clk), .rst(rst_s[gi]), .start(start_s[gi]), .mux_out(mux_out),
            .sel0(sel0), .sel1(sel1), .sel2(sel2),
            .data(data), .busy(busy), .done(done)
        );

        assign sel_o[gi]  = {sel2, sel1, sel0};
        assign data_o[gi] = data;
        assign busy_o[gi] = busy;
        assign done_o[gi] = done;

        // Reference: a scan is a run of 8*(S+1) cycles counted from the start edge;
        // channel k owns cycles k*(S+1)..k*(S+1)+S and is sampled at the end of its last one.
        bit         m_busy, m_done;
        int         m_t;
        logic [7:0] m_data, m_word;

        always @(posedge clk) begin : model
            bit         b, d;
            int         t;
            logic [7:0] w, dd;
            b = m_busy; d = m_done; t = m_t; w = m_word; dd = m_data;
            if (rst_s[gi]) begin
                b = 0; d = 0; t = 0; w = '0; dd = '0;
            end else if (b) begin
                if (t % (S + 1) == S) w[t / (S + 1)] = ch_s[gi][t / (S + 1)];
                t++;
                if (t == NUM_CH * (S + 1)) begin
                    b = 0; d = 1; dd = w;
                end
            end else begin
                d = 0;
                if (start_s[gi]) begin
                    b = 1; t = 0;
                end
            end
            m_busy <= b; m_done <= d; m_t <= t; m_word <= w; m_data <= dd;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk_val($sformatf("i%0d_sel", gi), 32'(sel_o[gi]),
                        32'(m_busy ? m_t / (S + 1) : (m_done ? 7 : 0)));
                chk_val($sformatf("i%0d_busy", gi), 32'(busy_o[gi]), 32'(m_busy));
                chk_val($sformatf("i%0d_done", gi), 32'(done_o[gi]), 32'(m_done));
                chk_val($sformatf("i%0d_data", gi), 32'(data_o[gi]), 32'(m_data));
                if (m_done) $display("inst%0d scan done data=%02h", gi, m_data);
            end
        end
    end

    function automatic int scan_len(input int inst);
        return NUM_CH * ((inst == 0) ? 2 : 1);
    endfunction

    // Called at a negedge; returns at the negedge on which done was seen.
    task automatic run_scan(input int inst, input logic [7:0] ch, input int extra_at,
                            input int tog_at, input logic [7:0] tog_mask,
                            input logic [7:0] exp_data, input string name);
        int cyc = 0;
        ch_s[inst]    = ch;
        start_s[inst] = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_s[inst] = 1'b0;
            if (cyc == extra_at) start_s[inst] = 1'b1;
            if (extra_at > 0 && cyc == extra_at + 1) start_s[inst] = 1'b0;
            if (cyc == tog_at) ch_s[inst] = ch_s[inst] ^ tog_mask;
            if (done_o[inst] === 1'b1 || cyc >= 300) break;
        end
        chk_val({name, "_latency"}, 32'(cyc - 1), 32'(scan_len(inst)));
        chk_val({name, "_data"}, 32'(data_o[inst]), 32'(exp_data));
        $display("%s: inst%0d done after %0d cycles data=%02h", name, inst, cyc - 1, data_o[inst]);
    endtask

    initial begin
        int last_done;
        int n_done;
        int cyc;
        for (int i = 0; i < N_INST; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; ch_s[i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < N_INST; i++) begin
            chk_val($sformatf("rst%0d_sel", i), 32'(sel_o[i]), 32'd0);
            chk_val($sformatf("rst%0d_data", i), 32'(data_o[i]), 32'h00);
            chk_val($sformatf("rst%0d_busy", i), 32'(busy_o[i]), 32'd0);
            chk_val($sformatf("rst%0d_done", i), 32'(done_o[i]), 32'd0);
            rst_s[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        run_scan(0, 8'hAA, 0, 0, 8'h00, 8'hAA, "alt_pattern");
        repeat (3) @(negedge clk);
        run_scan(1, 8'hFF, 0, 0, 8'h00, 8'hFF, "no_settle");
        repeat (3) @(negedge clk);

        // start held high: back-to-back scans 17 cycles apart
        ch_s[0] = 8'h01;
        start_s[0] = 1'b1;
        cyc = 0; n_done = 0; last_done = 0;
        while (n_done < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_o[0] === 1'b1) begin
                if (n_done > 0) chk_val("b2b_gap", 32'(cyc - last_done), 32'(scan_len(0) + 1));
                chk_val("b2b_data", 32'(data_o[0]), 32'h01);
                $display("back_to_back: done #%0d at cycle %0d data=%02h", n_done, cyc, data_o[0]);
                last_done = cyc;
                n_done++;
            end
        end
        chk_val("b2b_count", 32'(n_done), 32'd3);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);

        run_scan(0, 8'h5C, 5, 0, 8'h00, 8'h5C, "ignored_start");
        repeat (20) @(negedge clk);

        // reset in the middle of a scan discards everything
        run_scan(0, 8'hAA, 0, 0, 8'h00, 8'hAA, "pre_reset");
        @(negedge clk);
        ch_s[0] = 8'h3C;
        start_s[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start_s[0] = 1'b0;
        end
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk_val("midrst_data", 32'(data_o[0]), 32'h00);
        chk_val("midrst_sel", 32'(sel_o[0]), 32'd0);
        chk_val("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk_val("midrst_done", 32'(done_o[0]), 32'd0);
        $display("mid_reset: outputs cleared data=%02h", data_o[0]);
        @(negedge clk);
        run_scan(0, 8'h3C, 0, 0, 8'h00, 8'h3C, "post_reset");
        repeat (3) @(negedge clk);

        // channel c changes during its settle cycle; the sample edge value wins
        run_scan(0, 8'h00, 0, 5, 8'h04, 8'h04, "settle_toggle");
        repeat (3) @(negedge clk);

        // randomized traffic, checked cycle by cycle against the reference
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            for (int i = 0; i < N_INST; i++) begin
                if ($urandom_range(0, 3) == 0) ch_s[i] = 8'($urandom);
                start_s[i] = ($urandom_range(0, 9) == 0);
                rst_s[i]   = ($urandom_range(0, 199) == 0);
            end
        end
        for (int i = 0; i < N_INST; i++) begin
            start_s[i] = 1'b0; rst_s[i] = 1'b0;
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
